layer_compositor: RTL
=====================

# layer_compositor

Pipelined N-layer pixel compositor for the video path: blends `N_LAYERS` stacked layers (layer 0 bottom, layer `N_LAYERS-1` top) over a fixed background colour, one pixel per cycle, with binary-key or fractional alpha. It generalises the two-layer combinational key mux to arbitrary layer count, multi-bit alpha, per-pixel layer enables and a valid/ready stream with backpressure. It sits between the sprite/tile fetch units and the VGA output formatter.

## Interface

- `N_LAYERS`, 4, number of layers (≥1)
- `DEPTH`, 4, bits per colour channel
- `ALPHA_W`, 1, alpha bits per layer; 1 = binary key, >1 = blend
- `BG_R` / `BG_G` / `BG_B`, 0, background colour under layer 0 (`DEPTH` bits each)

- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input pixel bundle valid
- `in_ready`  out  1  block accepts bundle this cycle
- `in_r`, `in_g`, `in_b`  in  `N_LAYERS*DEPTH`  per-layer colour; layer k at `[k*DEPTH +: DEPTH]`
- `in_a`  in  `N_LAYERS*ALPHA_W`  per-layer alpha; layer k at `[k*ALPHA_W +: ALPHA_W]`
- `in_layer_en`  in  `N_LAYERS`  per-pixel layer enable; disabled layer treated as alpha 0
- `in_last`  in  1  end-of-line marker, passed through
- `out_valid`  out  1  composited pixel valid
- `out_ready`  in  1  downstream accepts
- `out_r`, `out_g`, `out_b`  out  `DEPTH`  composited colour
- `out_cov`  out  1  1 if any enabled layer had nonzero alpha
- `out_last`  out  1  delayed `in_last`

## Operation

- Stage k (k = 0..N_LAYERS-1) blends layer k over the accumulator from stage k-1; stage 0 accumulator input is the background colour with cov=0.
- Layers above k travel alongside in per-stage shift registers; each stage drops the layer it consumed.
- Effective alpha `a` = `in_layer_en[k] ? in_a[k] : 0`; `AMAX` = 2^ALPHA_W−1.
- Per channel: `a == AMAX` → curr; `a == 0` → prev; otherwise `(a*curr + (AMAX−a)*prev) >> ALPHA_W`. Products are computed at `DEPTH+ALPHA_W+1` bits, result truncated to `DEPTH`; no overflow is possible.
- With `ALPHA_W = 1` the rule reduces exactly to the key mux: `a ? curr : prev`.
- cov_next = cov_prev | (a != 0).
- `in_last` and `in_layer_en` ride in the stage that holds their pixel; no pixel reordering.

## Timing

- Latency: exactly `N_LAYERS` cycles from accepted input to `out_valid` when not stalled.
- Throughput: one pixel per cycle with `out_ready` held high.
- Global advance `adv = !out_valid || out_ready`; all stage registers, including valid bits, load only when `adv`. `in_ready = adv` (combinational).
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`. Bubbles (`in_valid=0` while `adv`) propagate as invalid stages.
- While `out_valid && !out_ready`, all outputs hold stable and `in_ready=0`.
- Reset (async assert, sync-released by the top-level synchroniser): all stage valid bits 0, all data registers 0. Hence `out_valid=0`, `out_r/g/b=0`, `out_cov=0`, `out_last=0`, `in_ready=1`. Reset mid-stream discards every in-flight pixel; there is no flush handshake.
- `N_LAYERS = 1`: single registered stage, latency 1.

## Structure

- `compositor_pkg`: `AMAX` computation function, `pixel_t` struct (r, g, b, cov, last), `blend_ch` function implementing the per-channel rule.
- One sub-module `blend_stage`: registered single-layer blend over accumulator with `adv` enable, parameterised on `DEPTH`/`ALPHA_W`; the top instantiates `N_LAYERS` of them via generate and owns the passenger shift registers and handshake.

## Test plan

- Binary key, `N_LAYERS=4, ALPHA_W=1`, BG=0: layer 2 = (5,6,7) a=1, layer 3 a=0, others a=0 → out (5,6,7), cov=1, exactly 4 cycles after transfer.
- Priority: layers 0 and 3 both opaque with (1,1,1) and (15,0,9) → out (15,0,9); clear `in_layer_en[3]` → (1,1,1).
- Blend, `ALPHA_W=4`, BG=0: layer 0 = (15,15,15) a=8 → (7,7,7); a=15 → (15,15,15); a=0 → (0,0,0), cov=0.
- Backpressure: stream 10 distinct pixels with `out_ready` toggling pseudo-randomly → all 10 emerge in order, no duplicates or drops, outputs stable while stalled, `out_last` aligned to the 10th.
- Bubbles: `in_valid` pattern 1,0,1,1,0 with `out_ready=1` → `out_valid` pattern 1,0,1,1,0 delayed by `N_LAYERS`.
- Reset mid-stream: assert `rst_n=0` with 3 pixels in flight → `out_valid`, `out_r/g/b`, `out_cov`, `out_last` drop to 0 immediately, `in_ready=1`; no stale pixels after release.

Source files
------------

// File: rtl/compositor_pkg.sv
// compositor_pkg: shared pixel type and per-channel blend arithmetic
// for the layer_compositor pipeline.
package compositor_pkg;

  localparam int PIX_DEPTH = 4;

  typedef struct packed {
    logic [PIX_DEPTH-1:0] r;
    logic [PIX_DEPTH-1:0] g;
    logic [PIX_DEPTH-1:0] b;
    logic                 cov;
    logic                 last;
  } pixel_t;

  function automatic int unsigned amax(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  // Endpoints bypass the multiply so full/zero alpha are exact.
  function automatic int unsigned blend_ch(
    input int unsigned a,
    input int unsigned curr,
    input int unsigned prev,
    input int          aw
  );
    int unsigned m;
    m = amax(aw);
    if (a == m) return curr;
    if (a == 0) return prev;
    return (a * curr + (m - a) * prev) >> aw;
  endfunction

endpackage

// File: rtl/blend_stage.sv
// blend_stage: one registered compositing stage; blends a single layer
// over the accumulated pixel arriving from the stage below.
module blend_stage
  import compositor_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALPHA_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_adv,
  input  logic               i_vld,
  input  logic [DEPTH-1:0]   i_pr,
  input  logic [DEPTH-1:0]   i_pg,
  input  logic [DEPTH-1:0]   i_pb,
  input  logic               i_pcov,
  input  logic               i_plast,
  input  logic [DEPTH-1:0]   i_cr,
  input  logic [DEPTH-1:0]   i_cg,
  input  logic [DEPTH-1:0]   i_cb,
  input  logic [ALPHA_W-1:0] i_ca,
  input  logic               i_en,
  output logic               o_vld,
  output logic [DEPTH-1:0]   o_r,
  output logic [DEPTH-1:0]   o_g,
  output logic [DEPTH-1:0]   o_b,
  output logic               o_cov,
  output logic               o_last
);

  logic [ALPHA_W-1:0] w_a;
  logic               r_vld;
  logic [DEPTH-1:0]   r_r;
  logic [DEPTH-1:0]   r_g;
  logic [DEPTH-1:0]   r_b;
  logic               r_cov;
  logic               r_last;

  assign w_a = i_en ? i_ca : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_cov  <= 1'b0;
      r_last <= 1'b0;
    end else if (i_adv) begin
      r_vld  <= i_vld;
      r_r    <= DEPTH'(blend_ch(32'(w_a), 32'(i_cr), 32'(i_pr), ALPHA_W));
      r_g    <= DEPTH'(blend_ch(32'(w_a), 32'(i_cg), 32'(i_pg), ALPHA_W));
      r_b    <= DEPTH'(blend_ch(32'(w_a), 32'(i_cb), 32'(i_pb), ALPHA_W));
      r_cov  <= i_pcov | (w_a != '0);
      r_last <= i_plast;
    end
  end

  assign o_vld  = r_vld;
  assign o_r    = r_r;
  assign o_g    = r_g;
  assign o_b    = r_b;
  assign o_cov  = r_cov;
  assign o_last = r_last;

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: N-stage pipelined layer blender over a background
// colour, one pixel per cycle with a global-stall valid/ready stream.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int               N_LAYERS = 4,
  parameter int               DEPTH    = 4,
  parameter int               ALPHA_W  = 1,
  parameter logic [DEPTH-1:0] BG_R     = '0,
  parameter logic [DEPTH-1:0] BG_G     = '0,
  parameter logic [DEPTH-1:0] BG_B     = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_LAYERS*DEPTH-1:0]   in_r,
  input  logic [N_LAYERS*DEPTH-1:0]   in_g,
  input  logic [N_LAYERS*DEPTH-1:0]   in_b,
  input  logic [N_LAYERS*ALPHA_W-1:0] in_a,
  input  logic [N_LAYERS-1:0]         in_layer_en,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH-1:0]            out_r,
  output logic [DEPTH-1:0]            out_g,
  output logic [DEPTH-1:0]            out_b,
  output logic                        out_cov,
  output logic                        out_last
);

  // One layer word: {en, a, b, g, r}
  localparam int LW = 3 * DEPTH + ALPHA_W + 1;
  localparam int PW = N_LAYERS * LW;

  logic             w_adv;
  logic [PW-1:0]    w_in_pk;
  logic [PW-1:0]    w_up    [N_LAYERS];
  logic [PW-1:0]    r_pass  [N_LAYERS];
  logic             w_pv    [N_LAYERS];
  logic [DEPTH-1:0] w_pr    [N_LAYERS];
  logic [DEPTH-1:0] w_pg    [N_LAYERS];
  logic [DEPTH-1:0] w_pb    [N_LAYERS];
  logic             w_pcov  [N_LAYERS];
  logic             w_plast [N_LAYERS];
  logic             w_vld   [N_LAYERS];
  logic [DEPTH-1:0] w_r     [N_LAYERS];
  logic [DEPTH-1:0] w_g     [N_LAYERS];
  logic [DEPTH-1:0] w_b     [N_LAYERS];
  logic             w_cov   [N_LAYERS];
  logic             w_last  [N_LAYERS];

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_in_pk = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      w_in_pk[k*LW +: LW] = {in_layer_en[k],
                             in_a[k*ALPHA_W +: ALPHA_W],
                             in_b[k*DEPTH +: DEPTH],
                             in_g[k*DEPTH +: DEPTH],
                             in_r[k*DEPTH +: DEPTH]};
    end
  end

  always_comb begin
    w_up[0]    = w_in_pk;
    w_pv[0]    = in_valid;
    w_pr[0]    = BG_R;
    w_pg[0]    = BG_G;
    w_pb[0]    = BG_B;
    w_pcov[0]  = 1'b0;
    w_plast[0] = in_last;
    for (int k = 1; k < N_LAYERS; k++) begin
      w_up[k]    = r_pass[k-1];
      w_pv[k]    = w_vld[k-1];
      w_pr[k]    = w_r[k-1];
      w_pg[k]    = w_g[k-1];
      w_pb[k]    = w_b[k-1];
      w_pcov[k]  = w_cov[k-1];
      w_plast[k] = w_last[k-1];
    end
  end

  // Upper layers ride along; each stage shifts out the layer it consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LAYERS; k++) r_pass[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < N_LAYERS; k++) r_pass[k] <= w_up[k] >> LW;
    end
  end

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_st
    blend_stage #(
      .DEPTH   (DEPTH),
      .ALPHA_W (ALPHA_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_vld   (w_pv[k]),
      .i_pr    (w_pr[k]),
      .i_pg    (w_pg[k]),
      .i_pb    (w_pb[k]),
      .i_pcov  (w_pcov[k]),
      .i_plast (w_plast[k]),
      .i_cr    (w_up[k][0 +: DEPTH]),
      .i_cg    (w_up[k][DEPTH +: DEPTH]),
      .i_cb    (w_up[k][2*DEPTH +: DEPTH]),
      .i_ca    (w_up[k][3*DEPTH +: ALPHA_W]),
      .i_en    (w_up[k][3*DEPTH+ALPHA_W]),
      .o_vld   (w_vld[k]),
      .o_r     (w_r[k]),
      .o_g     (w_g[k]),
      .o_b     (w_b[k]),
      .o_cov   (w_cov[k]),
      .o_last  (w_last[k])
    );
  end

  assign out_valid = w_vld[N_LAYERS-1];
  assign out_r     = w_r[N_LAYERS-1];
  assign out_g     = w_g[N_LAYERS-1];
  assign out_b     = w_b[N_LAYERS-1];
  assign out_cov   = w_cov[N_LAYERS-1];
  assign out_last  = w_last[N_LAYERS-1];

endmodule
